// File: rtl/sdrc_wb_arbiter_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package sdrc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    REL  = 2'd3
  } arb_state_e;

  typedef logic [1:0] gnt_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/sdrc_wb_arbiter_if.sv
// One Wishbone link; the master modport drives the request side, the slave modport answers.
interface sdrc_wb_if #(
  parameter int AW = 25,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic            ack;
  logic [DW-1:0]   dat_r;

  modport master (output cyc, stb, we, addr, dat_w, sel, cti, input ack, dat_r);
  modport slave  (input cyc, stb, we, addr, dat_w, sel, cti, output ack, dat_r);
endinterface

// File: rtl/sdrc_wb_arbiter_mux.sv
// Grant-indexed steering between the two masters and the SDRAM controller port.
module sdrc_arb_mux
  import sdrc_arb_pkg::*;
#(
  parameter int AW = 25,
  parameter int DW = 32
) (
  input  gnt_t            gnt,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [2:0]      m0_cti,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [2:0]      m1_cti,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  output logic [2:0]      s_cti,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dat_r,
  output logic            m0_ack,
  output logic            m1_ack,
  output logic [DW-1:0]   m0_dat_r,
  output logic [DW-1:0]   m1_dat_r
);

  // Payload follows the grant bit; cyc/stb/ack are masked so no grant means a quiet bus.
  always_comb begin
    s_we     = gnt[1] ? m1_we    : m0_we;
    s_addr   = gnt[1] ? m1_addr  : m0_addr;
    s_dat_w  = gnt[1] ? m1_dat_w : m0_dat_w;
    s_sel    = gnt[1] ? m1_sel   : m0_sel;
    s_cti    = gnt[1] ? m1_cti   : m0_cti;
    s_cyc    = (gnt[0] & m0_cyc) | (gnt[1] & m1_cyc);
    s_stb    = (gnt[0] & m0_stb) | (gnt[1] & m1_stb);
    m0_ack   = gnt[0] & s_ack;
    m1_ack   = gnt[1] & s_ack;
    m0_dat_r = s_dat_r;
    m1_dat_r = s_dat_r;
  end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin arbiter with cycle locking and an ack quantum in front of the SDRAM controller.
module sdrc_wb_arbiter
  import sdrc_arb_pkg::*;
#(
  parameter int AW      = 25,
  parameter int DW      = 32,
  parameter int QUANTUM = 16,
  parameter int QW      = 5
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_i,
  sdrc_wb_if.slave  m0,
  sdrc_wb_if.slave  m1,
  sdrc_wb_if.master s,
  output gnt_t      gnt_o
);

  localparam logic [QW-1:0] CNT_MAX    = '1;
  localparam logic [QW-1:0] QUANT      = QW'(QUANTUM);
  localparam bit            PREEMPT_EN = (QUANTUM != 0);

  arb_state_e    state, state_next;
  logic          last_owner;
  logic [QW-1:0] ack_cnt, ack_cnt_next, cnt_inc;
  logic          req0, req1, own_cyc, other_req, beat_ends;
  logic [2:0]    own_cti;
  gnt_t          gnt, mux_gnt;

  assign req0    = m0.cyc & m0.stb;
  assign req1    = m1.cyc & m1.stb;
  assign gnt     = {state == OWN1, state == OWN0};
  // Reset silences the slave side in the same cycle rather than one edge later.
  assign mux_gnt = wb_rst_i ? 2'b00 : gnt;
  assign gnt_o   = mux_gnt;

  always_comb begin
    own_cyc   = (state == OWN1) ? m1.cyc : m0.cyc;
    own_cti   = (state == OWN1) ? m1.cti : m0.cti;
    other_req = (state == OWN1) ? req0 : req1;
    beat_ends = s.ack && (own_cti == CTI_CLASSIC || own_cti == CTI_EOB);
    cnt_inc   = (s.ack && ack_cnt != CNT_MAX) ? ack_cnt + QW'(1) : ack_cnt;
  end

  // The quantum test includes the ack of the current beat, so the master gets exactly QUANTUM acks.
  always_comb begin
    state_next   = state;
    ack_cnt_next = '0;
    case (state)
      IDLE: begin
        if (req0 && req1) state_next = last_owner ? OWN0 : OWN1;
        else if (req0)    state_next = OWN0;
        else if (req1)    state_next = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_cyc)
          state_next = IDLE;
        else if (PREEMPT_EN && beat_ends && other_req && cnt_inc >= QUANT)
          state_next = REL;
        else
          ack_cnt_next = cnt_inc;
      end
      REL:     state_next = last_owner ? OWN0 : OWN1;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      ack_cnt    <= '0;
    end else begin
      state   <= state_next;
      ack_cnt <= ack_cnt_next;
      if (state_next == OWN0 && state != OWN0)
        last_owner <= 1'b0;
      else if (state_next == OWN1 && state != OWN1)
        last_owner <= 1'b1;
    end
  end

  sdrc_arb_mux #(.AW(AW), .DW(DW)) u_mux (
    .gnt      (mux_gnt),
    .m0_cyc   (m0.cyc),
    .m0_stb   (m0.stb),
    .m0_we    (m0.we),
    .m0_addr  (m0.addr),
    .m0_dat_w (m0.dat_w),
    .m0_sel   (m0.sel),
    .m0_cti   (m0.cti),
    .m1_cyc   (m1.cyc),
    .m1_stb   (m1.stb),
    .m1_we    (m1.we),
    .m1_addr  (m1.addr),
    .m1_dat_w (m1.dat_w),
    .m1_sel   (m1.sel),
    .m1_cti   (m1.cti),
    .s_cyc    (s.cyc),
    .s_stb    (s.stb),
    .s_we     (s.we),
    .s_addr   (s.addr),
    .s_dat_w  (s.dat_w),
    .s_sel    (s.sel),
    .s_cti    (s.cti),
    .s_ack    (s.ack),
    .s_dat_r  (s.dat_r),
    .m0_ack   (m0.ack),
    .m1_ack   (m1.ack),
    .m0_dat_r (m0.dat_r),
    .m1_dat_r (m1.dat_r)
  );

endmodule
